// File: rtl/cache_evt_perf_counter_if.sv
// Event/control/display bundle for cache_evt_perf_counter.
// master drives strobes and selects; slave is the counter block.
interface cache_evt_perf_counter_if #(
  parameter int NUM_EVT = 8,
  parameter int CNT_W   = 32
);
  localparam int BYTES = (CNT_W + 7) / 8;
  localparam int CH_W  = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
  localparam int BY_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic               enb;
  logic [NUM_EVT-1:0] evt_i;
  logic               clr_i;
  logic               snap_i;
  logic               scan_i;
  logic [CH_W-1:0]    sel_ch_i;
  logic [BY_W-1:0]    sel_byte_i;
  logic [7:0]         data_o;
  logic [CH_W-1:0]    cur_ch_o;
  logic [BY_W-1:0]    cur_byte_o;
  logic [NUM_EVT-1:0] ovf_o;

  modport master (
    output enb,
    output evt_i,
    output clr_i,
    output snap_i,
    output scan_i,
    output sel_ch_i,
    output sel_byte_i,
    input  data_o,
    input  cur_ch_o,
    input  cur_byte_o,
    input  ovf_o
  );

  modport slave (
    input  enb,
    input  evt_i,
    input  clr_i,
    input  snap_i,
    input  scan_i,
    input  sel_ch_i,
    input  sel_byte_i,
    output data_o,
    output cur_ch_o,
    output cur_byte_o,
    output ovf_o
  );
endinterface

// File: rtl/cache_evt_perf_counter.sv
// Multi-channel edge-counting perf counter with snapshot and byte display.
// Define EVT_CNT_SAT_EN to saturate counters instead of wrapping.
module cache_evt_perf_counter #(
  parameter int NUM_EVT = 8,
  parameter int CNT_W   = 32,
  parameter int SCAN_W  = 24
) (
  input logic clk,
  input logic rst,
  cache_evt_perf_counter_if.slave bus
);
  localparam int BYTES = (CNT_W + 7) / 8;
  localparam int CH_W  = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
  localparam int BY_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_EVT - 1);
  localparam logic [BY_W-1:0]  BY_LAST = BY_W'(BYTES - 1);
`ifdef EVT_CNT_SAT_EN
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;
`endif

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_SCAN   = 1'b1
  } state_t;

  logic [NUM_EVT-1:0] r_evt_d;
  logic [NUM_EVT-1:0] r_ovf;
  logic [CNT_W-1:0]   r_cnt    [NUM_EVT];
  logic [CNT_W-1:0]   r_shadow [NUM_EVT];

  state_t             r_state;
  logic [SCAN_W-1:0]  r_tmr;
  logic [CH_W-1:0]    r_ch;
  logic [BY_W-1:0]    r_byte;
  logic [7:0]         r_data;

  logic [NUM_EVT-1:0] w_hit;
  state_t             w_state_nxt;
  logic [SCAN_W-1:0]  w_tmr_nxt;
  logic [CH_W-1:0]    w_ch_nxt;
  logic [BY_W-1:0]    w_byte_nxt;
  logic [CNT_W-1:0]   w_sel_cnt;
  logic [BYTES*8-1:0] w_ext;
  logic [7:0]         w_data_nxt;

  assign w_hit = bus.evt_i & ~r_evt_d & {NUM_EVT{bus.enb}};

  // Snapshot reads r_cnt before this edge's clear/increment lands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_d <= '0;
      r_ovf   <= '0;
      for (int k = 0; k < NUM_EVT; k++) begin
        r_cnt[k]    <= '0;
        r_shadow[k] <= '0;
      end
    end else begin
      r_evt_d <= bus.evt_i;
      for (int k = 0; k < NUM_EVT; k++) begin
        if (bus.snap_i) begin
          r_shadow[k] <= r_cnt[k];
        end
        if (bus.clr_i) begin
          r_cnt[k] <= '0;
          r_ovf[k] <= 1'b0;
        end else if (w_hit[k]) begin
`ifdef EVT_CNT_SAT_EN
          if (r_cnt[k] != CNT_MAX) begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
          end
          if (r_cnt[k] == CNT_PRE) begin
            r_ovf[k] <= 1'b1;
          end
`else
          r_cnt[k] <= r_cnt[k] + 1'b1;
          if (r_cnt[k] == CNT_MAX) begin
            r_ovf[k] <= 1'b1;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_MANUAL;
      r_tmr   <= '0;
      r_ch    <= '0;
      r_byte  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_ch    <= w_ch_nxt;
      r_byte  <= w_byte_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Mode changes take effect on the same edge that sees scan_i
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_ch_nxt    = r_ch;
    w_byte_nxt  = r_byte;
    unique case (r_state)
      S_MANUAL: begin
        if (bus.scan_i) begin
          w_state_nxt = S_SCAN;
          w_tmr_nxt   = '0;
          w_ch_nxt    = '0;
          w_byte_nxt  = '0;
        end else begin
          w_ch_nxt    = bus.sel_ch_i;
          w_byte_nxt  = bus.sel_byte_i;
        end
      end
      S_SCAN: begin
        if (!bus.scan_i) begin
          w_state_nxt = S_MANUAL;
          w_tmr_nxt   = '0;
          w_ch_nxt    = bus.sel_ch_i;
          w_byte_nxt  = bus.sel_byte_i;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
          if (r_tmr == '1) begin
            if (r_byte == BY_LAST) begin
              w_byte_nxt = '0;
              if (r_ch == CH_LAST) begin
                w_ch_nxt = '0;
              end else begin
                w_ch_nxt = r_ch + 1'b1;
              end
            end else begin
              w_byte_nxt = r_byte + 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_MANUAL;
      end
    endcase
  end

  // Out-of-range channel or byte matches nothing and reads as zero
  always_comb begin
    w_sel_cnt  = '0;
    w_ext      = '0;
    w_data_nxt = 8'h00;
    for (int c = 0; c < NUM_EVT; c++) begin
      if (w_ch_nxt == CH_W'(c)) begin
        w_sel_cnt = r_shadow[c];
      end
    end
    w_ext[CNT_W-1:0] = w_sel_cnt;
    for (int b = 0; b < BYTES; b++) begin
      if (w_byte_nxt == BY_W'(b)) begin
        w_data_nxt = w_ext[8*b +: 8];
      end
    end
  end

  assign bus.data_o     = r_data;
  assign bus.cur_ch_o   = r_ch;
  assign bus.cur_byte_o = r_byte;
  assign bus.ovf_o      = r_ovf;
endmodule
